// File: rtl/i2s_capture.sv
// i2s_capture: I2S ADC receiver that packs samples little-endian into a
// double-buffered byte RAM. Optional overrun counter: I2S_CAPTURE_OVERRUN_CNT_EN.

module i2s_capture #(
    parameter int BUFFER_ADDR_BITS = 9,
    parameter int SAMPLE_BITS      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      capture_en_i,
    input  logic                      capture_mono_i,
    input  logic                      aud_bclk_i,
    input  logic                      aud_adclrck_i,
    input  logic                      aud_adcdat_i,
    output logic [BUFFER_ADDR_BITS:0] buffer_addr_o,
    output logic [7:0]                buffer_data_o,
    output logic                      buffer_wren_o,
    output logic                      buffer_filled_o,
    input  logic                      buffer_filled_ack_i,
`ifdef I2S_CAPTURE_OVERRUN_CNT_EN
    output logic [15:0]               buffer_overrun_cnt_o,
`endif
    output logic                      buffer_overrun_o
);

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        SKIP,
        SHIFT,
        HOLD,
        WR_LO,
        WR_HI
    } state_t;

    localparam logic [4:0] LAST_BIT = 5'(SAMPLE_BITS - 1);
    localparam logic [BUFFER_ADDR_BITS-1:0] PTR_ONE = 1;
    localparam logic [BUFFER_ADDR_BITS-1:0] PTR_MAX = '1;

    logic bclk_s1_q, bclk_s2_q, bclk_prev_q;
    logic lrck_s1_q, lrck_s2_q, lrck_q;
    logic dat_s1_q, dat_s2_q;

    state_t state_q, state_d;
    logic [BUFFER_ADDR_BITS-1:0] ptr_q, ptr_d;
    logic half_q, half_d;
    logic filled_q, filled_d;
    logic ovr_q, ovr_d;
    logic [15:0] shreg_q, shreg_d;
    logic [4:0] cnt_q, cnt_d;
    logic chan_q, chan_d;
    logic mono_q, mono_d;

    logic bclk_rise;
    logic lrck_edge;
    logic lrck_fall;
    logic keep;
    logic wr;
    logic [7:0] wdata;

    assign bclk_rise = bclk_s2_q & ~bclk_prev_q;
    assign lrck_edge = bclk_rise & (lrck_s2_q ^ lrck_q);
    assign lrck_fall = lrck_edge & ~lrck_s2_q;
    assign keep      = ~mono_q | ~chan_q;

    // Synchronise codec clocks/data and keep the LRCK copy seen at each BCLK rise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bclk_s1_q   <= 1'b0;
            bclk_s2_q   <= 1'b0;
            bclk_prev_q <= 1'b0;
            lrck_s1_q   <= 1'b0;
            lrck_s2_q   <= 1'b0;
            lrck_q      <= 1'b0;
            dat_s1_q    <= 1'b0;
            dat_s2_q    <= 1'b0;
        end else begin
            bclk_s1_q   <= aud_bclk_i;
            bclk_s2_q   <= bclk_s1_q;
            bclk_prev_q <= bclk_s2_q;
            lrck_s1_q   <= aud_adclrck_i;
            lrck_s2_q   <= lrck_s1_q;
            dat_s1_q    <= aud_adcdat_i;
            dat_s2_q    <= dat_s1_q;
            if (bclk_rise) begin
                lrck_q <= lrck_s2_q;
            end
        end
    end

    // Capture state, write pointer, half select and handshake registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            half_q   <= 1'b0;
            filled_q <= 1'b0;
            ovr_q    <= 1'b0;
            shreg_q  <= '0;
            cnt_q    <= '0;
            chan_q   <= 1'b0;
            mono_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            half_q   <= half_d;
            filled_q <= filled_d;
            ovr_q    <= ovr_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            chan_q   <= chan_d;
            mono_q   <= mono_d;
        end
    end

    // Next-state: word alignment, bit shifting, byte writes and half swapping
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        half_d   = half_q;
        filled_d = filled_q;
        ovr_d    = 1'b0;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        chan_d   = chan_q;
        mono_d   = mono_q;
        wr       = 1'b0;
        wdata    = 8'h00;

        // LRCK level after an edge names the channel now arriving (1 = right)
        if (lrck_edge) begin
            chan_d = lrck_s2_q;
        end

        if (filled_q && buffer_filled_ack_i) begin
            filled_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (capture_en_i) begin
                    ptr_d   = '0;
                    state_d = ALIGN;
                end
            end
            ALIGN: begin
                mono_d = capture_mono_i;
                if (!capture_en_i) begin
                    state_d = IDLE;
                end else if (lrck_fall) begin
                    state_d = SKIP;
                end
            end
            SKIP: begin
                // The rise that revealed the LRCK edge carried the delay bit
                if (!capture_en_i) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (!capture_en_i) begin
                    state_d = IDLE;
                end else if (lrck_edge) begin
                    state_d = SKIP;
                end else if (bclk_rise) begin
                    shreg_d = {shreg_q[14:0], dat_s2_q};
                    cnt_d   = cnt_q + 5'd1;
                    if (cnt_q == LAST_BIT) begin
                        state_d = keep ? WR_LO : HOLD;
                    end
                end
            end
            HOLD: begin
                if (!capture_en_i) begin
                    state_d = IDLE;
                end else if (lrck_edge) begin
                    state_d = SKIP;
                end
            end
            WR_LO: begin
                wr    = 1'b1;
                wdata = shreg_q[7:0];
                if (SAMPLE_BITS == 8) begin
                    state_d = capture_en_i ? HOLD : IDLE;
                end else begin
                    state_d = WR_HI;
                end
            end
            WR_HI: begin
                wr      = 1'b1;
                wdata   = shreg_q[15:8];
                state_d = capture_en_i ? HOLD : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A wrap hands the half over unless the consumer still holds the other
        if (wr) begin
            ptr_d = ptr_q + PTR_ONE;
            if (ptr_q == PTR_MAX) begin
                if (!filled_q || buffer_filled_ack_i) begin
                    half_d   = ~half_q;
                    filled_d = 1'b1;
                end else begin
                    ovr_d = 1'b1;
                end
            end
        end
    end

    assign buffer_addr_o    = {half_q, ptr_q};
    assign buffer_data_o    = wdata;
    assign buffer_wren_o    = wr;
    assign buffer_filled_o  = filled_q;
    assign buffer_overrun_o = ovr_q;

`ifdef I2S_CAPTURE_OVERRUN_CNT_EN
    logic        en_q;
    logic [15:0] ovr_cnt_q;

    // Saturating overrun count, restarted by each new capture enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q      <= 1'b0;
            ovr_cnt_q <= '0;
        end else begin
            en_q <= capture_en_i;
            if (capture_en_i && !en_q) begin
                ovr_cnt_q <= '0;
            end else if (ovr_q && ovr_cnt_q != 16'hFFFF) begin
                ovr_cnt_q <= ovr_cnt_q + 16'd1;
            end
        end
    end

    assign buffer_overrun_cnt_o = ovr_cnt_q;
`else
    // Overrun pulses are exported only as the one-cycle buffer_overrun_o
`endif

endmodule

// File: tb/tb_i2s_capture.sv
// tb_i2s_capture: directed + random I2S frames against a byte-stream model
// of the double buffer (8-byte halves).

module tb_i2s_capture;

    localparam int AB   = 3;
    localparam int SLOT = 24;
    localparam int HALF = 40;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       mono = 1'b0;
    logic       bclk = 1'b0;
    logic       lrck = 1'b1;
    logic       dat = 1'b0;
    logic       ack = 1'b0;
    logic [AB:0] addr;
    logic [7:0] data;
    logic       wren;
    logic       filled;
    logic       ovr;
`ifdef I2S_CAPTURE_OVERRUN_CNT_EN
    logic [15:0] ovr_cnt;
`endif

    i2s_capture #(
        .BUFFER_ADDR_BITS(AB),
        .SAMPLE_BITS(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .capture_en_i(en),
        .capture_mono_i(mono),
        .aud_bclk_i(bclk),
        .aud_adclrck_i(lrck),
        .aud_adcdat_i(dat),
        .buffer_addr_o(addr),
        .buffer_data_o(data),
        .buffer_wren_o(wren),
        .buffer_filled_o(filled),
        .buffer_filled_ack_i(ack),
`ifdef I2S_CAPTURE_OVERRUN_CNT_EN
        .buffer_overrun_cnt_o(ovr_cnt),
`endif
        .buffer_overrun_o(ovr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_err = 0;

    logic [AB:0] got_addr[$];
    logic [7:0]  got_data[$];
    int          got_cyc[$];
    logic [AB:0] exp_addr[$];
    logic [7:0]  exp_data[$];

    int   ovr_pulses = 0;
    int   ovr_hi = 0;
    logic ovr_prev = 1'b0;
    logic filled_prev = 1'b0;
    int   filled_rise_cyc = -1;

    always @(negedge clk) begin
        if (wren) begin
            got_addr.push_back(addr);
            got_data.push_back(data);
            got_cyc.push_back(cyc);
        end
        if (filled && !filled_prev) filled_rise_cyc <= cyc;
        filled_prev <= filled;
        if (ovr) ovr_hi <= ovr_hi + 1;
        if (ovr && !ovr_prev) ovr_pulses <= ovr_pulses + 1;
        ovr_prev <= ovr;
    end

    // Model of the double buffer as a byte stream
    int m_half = 0;
    int m_ptr = 0;
    int m_filled = 0;
    int m_ovr = 0;
    int m_cnt = 0;
    int m_ack = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        exp_addr.push_back((AB+1)'(m_half * 8 + m_ptr));
        exp_data.push_back(b);
        if (m_ptr == 7) begin
            if (m_filled == 0 || m_ack != 0) begin
                m_half   = 1 - m_half;
                m_filled = 1;
            end else begin
                m_ovr++;
                m_cnt++;
            end
            m_ack = 0;
        end
        m_ptr = (m_ptr + 1) % 8;
    endtask

    task automatic model_frame(input logic [15:0] l, input logic [15:0] r,
                               input bit mo);
        model_byte(l[7:0]);
        model_byte(l[15:8]);
        if (!mo) begin
            model_byte(r[7:0]);
            model_byte(r[15:8]);
        end
    endtask

    task automatic clear_q();
        got_addr.delete();
        got_data.delete();
        got_cyc.delete();
        exp_addr.delete();
        exp_data.delete();
    endtask

    task automatic check_writes(input string tag);
        chk({tag, "_count"}, got_data.size(), exp_data.size());
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            chk({tag, "_addr"}, got_addr[i], exp_addr[i]);
            chk({tag, "_data"}, got_data[i], exp_data[i]);
        end
        clear_q();
    endtask

    logic prev_lsb = 1'b0;

    task automatic send_word(input logic ch, input logic [15:0] w);
        for (int b = 0; b < SLOT; b++) begin
            bclk = 1'b0;
            if (b == 0) begin
                lrck = ch;
                dat  = prev_lsb;
            end else if (b <= 16) begin
                dat = w[16-b];
            end else begin
                dat = 1'b0;
            end
            #(HALF);
            bclk = 1'b1;
            #(HALF);
        end
        prev_lsb = w[0];
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
        send_word(1'b0, l);
        send_word(1'b1, r);
    endtask

    task automatic pulse_bclk(input int n);
        for (int i = 0; i < n; i++) begin
            bclk = 1'b0;
            #(HALF);
            bclk = 1'b1;
            #(HALF);
        end
    endtask

    task automatic settle();
        repeat (6) @(negedge clk);
    endtask

    task automatic do_ack();
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        if (m_filled != 0) m_filled = 0;
    endtask

    task automatic enable_capture(input logic mo);
        @(negedge clk);
        en = 1'b0;
        repeat (4) @(negedge clk);
        mono = mo;
        en = 1'b1;
        m_ptr = 0;
        m_cnt = 0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] l, r;
        int n;
        int last;
        bit seen;

        // Reset state
        #23;
        chk("rst_addr", addr, 0);
        chk("rst_data", data, 0);
        chk("rst_wren", wren, 0);
        chk("rst_filled", filled, 0);
        chk("rst_ovr", ovr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Stereo A55A/1234, two frames fill half 0
        en = 1'b1;
        m_ptr = 0;
        repeat (4) @(negedge clk);
        send_word(1'b1, 16'h0000);
        clear_q();
        for (int f = 0; f < 2; f++) begin
            model_frame(16'hA55A, 16'h1234, 1'b0);
            send_frame(16'hA55A, 16'h1234);
        end
        settle();
        last = got_cyc.size() - 1;
        chk("stereo_pair_consec",
            (got_cyc.size() >= 2) ? got_cyc[1] - got_cyc[0] : -1, 1);
        chk("stereo_filled_lat",
            (last >= 0) ? filled_rise_cyc - got_cyc[last] : -1, 1);
        check_writes("stereo");
        chk("stereo_filled", filled, m_filled);
        chk("stereo_msb", addr[AB], m_half);

        // Ack clears filled on the next cycle
        do_ack();
        chk("ack_filled", filled, m_filled);

        // Random stereo frames into half 1
        for (int f = 0; f < 2; f++) begin
            l = 16'($urandom);
            r = 16'($urandom);
            model_frame(l, r, 1'b0);
            send_frame(l, r);
        end
        settle();
        check_writes("rand");
        chk("rand_filled", filled, m_filled);
        chk("rand_msb", addr[AB], m_half);

        // No ack across another full half: overrun
        for (int f = 0; f < 2; f++) begin
            l = 16'($urandom);
            r = 16'($urandom);
            model_frame(l, r, 1'b0);
            send_frame(l, r);
        end
        settle();
        check_writes("ovr");
        chk("ovr_pulses", ovr_pulses, m_ovr);
        chk("ovr_width", ovr_hi, m_ovr);
        chk("ovr_msb", addr[AB], m_half);
        chk("ovr_filled", filled, m_filled);
`ifdef I2S_CAPTURE_OVERRUN_CNT_EN
        chk("ovr_cnt", ovr_cnt, m_cnt);
`endif

        // Ack in the very cycle of the wrap write
        m_ack = 1;
        for (int f = 0; f < 2; f++) model_frame(16'h0F0F + 16'(f), 16'hC3C3, 1'b0);
        fork
            begin
                send_frame(16'h0F0F, 16'hC3C3);
                send_frame(16'h0F10, 16'hC3C3);
            end
            begin
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!(wren && addr[AB-1:0] == 3'd7) && n < 5000);
                seen = wren && addr[AB-1:0] == 3'd7;
                ack = 1'b1;
                @(negedge clk);
                ack = 1'b0;
                chk("ackwrap_seen", seen, 1);
            end
        join
        settle();
        check_writes("ackwrap");
        chk("ackwrap_filled", filled, m_filled);
        chk("ackwrap_msb", addr[AB], m_half);
        chk("ackwrap_no_ovr", ovr_pulses, m_ovr);
        do_ack();
        chk("ack2_filled", filled, m_filled);

        // Mono: only the left word is stored
        enable_capture(1'b1);
`ifdef I2S_CAPTURE_OVERRUN_CNT_EN
        chk("cnt_clr_on_en", ovr_cnt, m_cnt);
`endif
        clear_q();
        for (int f = 0; f < 4; f++) begin
            model_frame(16'hBEEF, 16'h0000, 1'b1);
            send_frame(16'hBEEF, 16'h0000);
        end
        settle();
        check_writes("mono");
        chk("mono_filled", filled, m_filled);
        chk("mono_msb", addr[AB], m_half);
        do_ack();

        // Enable rises during a right word: nothing until next left word
        @(negedge clk);
        en = 1'b0;
        mono = 1'b0;
        repeat (4) @(negedge clk);
        send_word(1'b0, 16'($urandom));
        bclk = 1'b0;
        lrck = 1'b1;
        pulse_bclk(3);
        en = 1'b1;
        m_ptr = 0;
        clear_q();
        send_word(1'b1, 16'($urandom));
        settle();
        chk("enrise_no_wr", got_data.size(), 0);
        l = 16'($urandom);
        r = 16'($urandom);
        model_frame(l, r, 1'b0);
        send_frame(l, r);
        settle();
        check_writes("enrise");

        // Enable drops during WR_LO: WR_HI still lands, then idle
        l = 16'($urandom);
        r = 16'($urandom);
        model_byte(l[7:0]);
        model_byte(l[15:8]);
        fork
            send_frame(l, r);
            begin
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!wren && n < 5000);
                seen = wren;
                en = 1'b0;
                chk("endrop_seen", seen, 1);
            end
        join
        settle();
        check_writes("endrop");
        send_frame(16'($urandom), 16'($urandom));
        settle();
        chk("endrop_idle", got_data.size(), 0);

        // Asynchronous reset in the middle of a left word
        @(negedge clk);
        en = 1'b1;
        repeat (3) @(negedge clk);
        clear_q();
        fork
            send_frame(16'h5555, 16'hAAAA);
            begin
                repeat (60) @(negedge clk);
                rst_n = 1'b0;
                #1;
                chk("arst_addr", addr, 0);
                chk("arst_data", data, 0);
                chk("arst_wren", wren, 0);
                chk("arst_filled", filled, 0);
                chk("arst_ovr", ovr, 0);
                m_half = 0;
                m_ptr = 0;
                m_filled = 0;
                m_cnt = 0;
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
            end
        join
        settle();
        chk("arst_no_wr", got_data.size(), 0);
        l = 16'($urandom);
        r = 16'($urandom);
        model_frame(l, r, 1'b0);
        send_frame(l, r);
        settle();
        check_writes("post_rst");
        chk("post_rst_filled", filled, m_filled);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/i2s_capture.md
Name: i2s_capture

Overview:
- I2S receiver for the audio codec ADC path: deserialises AUD_ADCDAT using the codec bit clock and ADC word clock.
- Packs each sample into little-endian bytes and writes them into a byte-wide dual-port RAM organised as a double buffer.
- Signals each completed half through a filled/ack handshake, so a downstream writer (e.g. an SD block writer) can drain it.
- Sits beside Codec and takes its BCLK/ADCLRCK; same clk domain as the rest of the player.

Parameters:
- BUFFER_ADDR_BITS, 9, byte address width of one buffer half (512 B = one SD block).
- SAMPLE_BITS, 16, bits captured per channel word, MSB first; must be 8 or 16.

Ports:
- clk  input  1  system clock (200 MHz)
- rst_n  input  1  reset, asynchronous, active-low
- capture_en_i  input  1  capture enable; level
- capture_mono_i  input  1  1 = store left channel only, 0 = store left+right
- aud_bclk_i  input  1  codec bit clock (asynchronous, slow relative to clk)
- aud_adclrck_i  input  1  ADC word clock; low = left
- aud_adcdat_i  input  1  ADC serial data
- buffer_addr_o  output  BUFFER_ADDR_BITS+1  RAM write address; MSB = half being written
- buffer_data_o  output  8  RAM write data
- buffer_wren_o  output  1  RAM write enable, one-cycle pulse per byte
- buffer_filled_o  output  1  a half is complete and ready for the consumer
- buffer_filled_ack_i  input  1  consumer has taken the filled half
- buffer_overrun_o  output  1  one-cycle pulse: a block was discarded

Behaviour:
- Reset: all outputs 0, write pointer 0, half select 0, state IDLE. Reset mid-operation aborts any partial sample or half with no write.
- Synchronisers: bclk, lrck and dat each pass through a 2-FF synchroniser.
  - BCLK rising edge is detected in clk from the synchronised value: one event per clk.
  - dat is sampled on that same event; an LRCK edge is seen on the BCLK rise where the synchronised LRCK differs from its stored copy.
- States: IDLE, ALIGN, SKIP, SHIFT, HOLD, WR_LO, WR_HI.
  - IDLE: wait for capture_en_i=1; clear the pointer (half select kept) -> ALIGN.
  - ALIGN: wait for an LRCK falling edge (start of left word), so stereo pairs stay aligned -> SKIP.
  - SKIP: discard the first BCLK rise after the LRCK edge (I2S one-bit delay) -> SHIFT.
  - SHIFT: shift in SAMPLE_BITS bits, MSB first, on BCLK rises.
    - Channel kept (stereo: both; mono: left only) -> WR_LO.
    - Otherwise -> HOLD.
  - WR_LO: write bits[7:0] at the pointer, pointer+1.
    - SAMPLE_BITS=8 -> HOLD.
    - Otherwise -> WR_HI.
  - WR_HI: write bits[15:8] at the pointer, pointer+1 -> HOLD.
  - HOLD: ignore remaining bits; on the next LRCK edge -> SKIP.
- Write timing: buffer_addr_o and buffer_data_o are valid in the same cycle as buffer_wren_o. A sample's bytes occupy consecutive cycles right after the last data bit.
- Pointer wrap (pointer goes from 2^BUFFER_ADDR_BITS-1 to 0 on a write):
  - buffer_filled_o=0: toggle the half select and set buffer_filled_o the next cycle.
  - buffer_filled_o=1 (consumer still busy): do not toggle, refill the same half from 0, pulse buffer_overrun_o.
- buffer_filled_o clears the cycle after buffer_filled_ack_i=1 is seen.
  - If the ack and a new wrap arrive in the same cycle, the wrap wins: the half toggles, filled stays 1, no overrun.
  - An ack seen while filled=0 is ignored.
- The consumer reads the half NOT indicated by buffer_addr_o MSB.
- capture_en_i=0 in any state:
  - After the current WR_LO/WR_HI pair completes (never a torn sample) -> IDLE.
  - The partial half is discarded; filled/ack handshake keeps working.
- capture_mono_i is sampled only in ALIGN; changes mid-capture take effect at the next enable.

Optional Feature:
- I2S_CAPTURE_OVERRUN_CNT_EN.
- Defined: adds output buffer_overrun_cnt_o [15:0], counting buffer_overrun_o pulses. It saturates at 16'hFFFF, is cleared by reset and by the capture_en_i rising edge, and changes one cycle after the pulse.
- Undefined: port absent, no counter logic; buffer_overrun_o unchanged.

Test Plan:
- Reset: rst_n low mid-SHIFT -> all outputs 0 immediately (async); no wren after release until a new LRCK falling edge.
- Stereo 16-bit, BUFFER_ADDR_BITS=3:
  - Stimulus: L=16'hA55A, R=16'h1234 for 2 frames.
  - Required writes: addr 0..7 = 5A,A5,34,12,5A,A5,34,12.
  - Then: MSB toggles to 1, filled=1 one cycle after the 8th write.
- Mono 16-bit:
  - Stimulus: L=16'hBEEF, R=16'h0000.
  - Required: only EF,BE written per frame; the right word produces no wren.
- Overrun: no ack across two full halves -> second wrap pulses overrun=1 for 1 cycle, MSB unchanged, filled stays 1. Counter =1 with the macro defined.
- Handshake:
  - Ack pulse while filled=1 -> filled=0 next cycle.
  - Ack and wrap in the same cycle -> filled stays 1, MSB toggles, no overrun.
- Enable/alignment:
  - capture_en_i rises while LRCK is high (right word) -> no writes until after the next LRCK falling edge.
  - Drop enable mid-WR_LO -> WR_HI still written, then IDLE.
